// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and types used by the write-back stage and register file.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam reg_idx_t X0 = 5'd0;

  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-write-back bus plus the decode read ports and commit status of the register file.
interface wb_regfile_if #(
  parameter int CNT_W = 32
);
  import riscv_pkg::*;

  xlen_t             mem_rd_data_in;
  xlen_t             data_in;
  reg_idx_t          mem_rd_addr_in;
  logic              memToReg_in;
  logic              regWrite_in;
  reg_idx_t          rs1_addr_in;
  reg_idx_t          rs2_addr_in;
  xlen_t             rs1_data_out;
  xlen_t             rs2_data_out;
  xlen_t             wb_data_out;
  logic              wb_we_out;
  logic [CNT_W-1:0]  wb_count_out;

  modport master (
    output mem_rd_data_in, data_in, mem_rd_addr_in, memToReg_in, regWrite_in,
    output rs1_addr_in, rs2_addr_in,
    input  rs1_data_out, rs2_data_out, wb_data_out, wb_we_out, wb_count_out
  );

  modport slave (
    input  mem_rd_data_in, data_in, mem_rd_addr_in, memToReg_in, regWrite_in,
    input  rs1_addr_in, rs2_addr_in,
    output rs1_data_out, rs2_data_out, wb_data_out, wb_we_out, wb_count_out
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Architectural integer register file: x0 reads zero, asynchronous clear, one write port
// and two combinational read ports with write-through bypass.
module regfile_2r1w
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we_in,
  input  reg_idx_t waddr_in,
  input  xlen_t    wdata_in,
  input  reg_idx_t rs1_addr_in,
  input  reg_idx_t rs2_addr_in,
  output xlen_t    rs1_data_out,
  output xlen_t    rs2_data_out
);

  xlen_t regs_d [NREGS];
  xlen_t regs_q [NREGS];
  logic  wr_en_s;

  function automatic xlen_t read_port(
    input reg_idx_t idx,
    input xlen_t    stored,
    input logic     we,
    input reg_idx_t waddr,
    input xlen_t    wdata
  );
    xlen_t val;
    if (idx == X0) begin
      val = '0;
    end else if (we && (idx == waddr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Next-state of the array; entry 0 is never written so it stays at its reset value of zero.
  always_comb begin
    wr_en_s = we_in && (waddr_in != X0);
    regs_d  = regs_q;
    if (wr_en_s) begin
      regs_d[waddr_in] = wdata_in;
    end else begin
      regs_d = regs_q;
    end
  end

  // Array storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports see a same-cycle write so decode never needs a separate WB forward.
  always_comb begin
    rs1_data_out = read_port(rs1_addr_in, regs_q[rs1_addr_in], wr_en_s, waddr_in, wdata_in);
    rs2_data_out = read_port(rs2_addr_in, regs_q[rs2_addr_in], wr_en_s, waddr_in, wdata_in);
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, gates the commit enable and counts
// committed register writes; the array itself lives in regfile_2r1w.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);

  xlen_t            wb_data_s;
  logic             wb_we_s;
  logic [CNT_W-1:0] wb_count_d;
  logic [CNT_W-1:0] wb_count_q;

  // Write-back mux and effective enable; rst_n gating kills a write pending when reset hits.
  always_comb begin
    if (wb_sel_e'(bus.memToReg_in) == WB_SEL_MEM) begin
      wb_data_s = bus.mem_rd_data_in;
    end else begin
      wb_data_s = bus.data_in;
    end
    wb_we_s = bus.regWrite_in && (bus.mem_rd_addr_in != X0) && rst_n;
  end

  // Commit counter next-state; wraps silently.
  always_comb begin
    wb_count_d = wb_count_q;
    if (wb_we_s) begin
      wb_count_d = wb_count_q + CNT_W'(1);
    end else begin
      wb_count_d = wb_count_q;
    end
  end

  // Commit counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  regfile_2r1w u_regfile (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_in        (wb_we_s),
    .waddr_in     (bus.mem_rd_addr_in),
    .wdata_in     (wb_data_s),
    .rs1_addr_in  (bus.rs1_addr_in),
    .rs2_addr_in  (bus.rs2_addr_in),
    .rs1_data_out (bus.rs1_data_out),
    .rs2_data_out (bus.rs2_data_out)
  );

  assign bus.wb_data_out  = wb_data_s;
  assign bus.wb_we_out    = wb_we_s;
  assign bus.wb_count_out = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a reference register-file model compared every
// negative clock edge, plus directed vectors with hand-computed expectations.
module tb_wb_regfile;

  logic clk;
  logic rst_n;
  logic do_preload;
  int   tests;
  int   fails;

  logic [31:0] mregs [32];
  logic [31:0] mcount;

  wb_regfile_if #(.CNT_W(32)) bus ();

  wb_regfile #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    return bus.memToReg_in ? bus.mem_rd_data_in : bus.data_in;
  endfunction

  function automatic logic exp_we();
    return rst_n && bus.regWrite_in && (bus.mem_rd_addr_in != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (exp_we() && idx == bus.mem_rd_addr_in) return exp_wb();
    return mregs[idx];
  endfunction

  // Reference model of the architectural state.
  always @(posedge clk or negedge rst_n or posedge do_preload) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      mcount <= 32'd0;
    end else if (do_preload) begin
      mcount <= 32'hFFFF_FFFF;
    end else if (bus.regWrite_in && bus.mem_rd_addr_in != 5'd0) begin
      mregs[bus.mem_rd_addr_in] <= exp_wb();
      mcount <= mcount + 32'd1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_wb_data", bus.wb_data_out, exp_wb());
    check("cyc_wb_we", {31'd0, bus.wb_we_out}, {31'd0, exp_we()});
    check("cyc_rs1", bus.rs1_data_out, exp_read(bus.rs1_addr_in));
    check("cyc_rs2", bus.rs2_data_out, exp_read(bus.rs2_addr_in));
    check("cyc_count", bus.wb_count_out, mcount);
  end

  task automatic drive(input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] mdata, input logic [31:0] adata,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.regWrite_in    = we;
    bus.memToReg_in    = m2r;
    bus.mem_rd_addr_in = rd;
    bus.mem_rd_data_in = mdata;
    bus.data_in        = adata;
    bus.rs1_addr_in    = r1;
    bus.rs2_addr_in    = r2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests      = 0;
    fails      = 0;
    do_preload = 1'b0;
    rst_n      = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    #1;
    check("reset_count", bus.wb_count_out, 32'd0);

    // Every index reads zero on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr_in = 5'(i);
      bus.rs2_addr_in = 5'(31 - i);
      #1;
      check("reset_rs1", bus.rs1_data_out, 32'd0);
      check("reset_rs2", bus.rs2_data_out, 32'd0);
    end

    // ALU result to x5.
    next_cycle();
    drive(1'b1, 1'b0, 5'd5, 32'h0BAD_0BAD, 32'h1234_5678, 5'd0, 5'd0);
    #1;
    check("alu_wb_data", bus.wb_data_out, 32'h1234_5678);
    check("alu_we", {31'd0, bus.wb_we_out}, 32'd1);
    next_cycle();

    // Load data to x7, read back x5 from the array then x7 through the bypass.
    drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0000_0000, 5'd5, 5'd5);
    #1;
    check("x5_readback", bus.rs1_data_out, 32'h1234_5678);
    check("count_one", bus.wb_count_out, 32'd1);
    bus.rs1_addr_in = 5'd7;
    bus.rs2_addr_in = 5'd7;
    #1;
    check("bypass_rs1", bus.rs1_data_out, 32'hDEAD_BEEF);
    check("bypass_rs2", bus.rs2_data_out, 32'hDEAD_BEEF);
    next_cycle();
    check("count_two", bus.wb_count_out, 32'd2);

    // Write to x0 is dropped and not counted; x7 now comes from the array.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd7);
    #1;
    check("x0_rs1", bus.rs1_data_out, 32'd0);
    check("x0_we", {31'd0, bus.wb_we_out}, 32'd0);
    check("x0_wb_data", bus.wb_data_out, 32'hFFFF_FFFF);
    check("x7_array", bus.rs2_data_out, 32'hDEAD_BEEF);
    next_cycle();
    check("x0_count", bus.wb_count_out, 32'd2);

    // Bubble still drives the mux; then counter wrap from all-ones.
    drive(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 32'h1, 5'd9, 5'd0);
    do_preload = 1'b1;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    do_preload = 1'b0;
    release dut.wb_count_q;
    #1;
    check("bubble_wb_data", bus.wb_data_out, 32'hCAFE_F00D);
    check("bubble_rs1", bus.rs1_data_out, 32'd0);
    check("preload_count", bus.wb_count_out, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b1, 1'b0, 5'd9, 32'd0, 32'h0000_0001, 5'd9, 5'd0);
    next_cycle();
    check("wrap_count", bus.wb_count_out, 32'd0);
    check("x9_readback", bus.rs1_data_out, 32'h0000_0001);

    // x3 committed, then reset drops mid-cycle while x4 is pending.
    drive(1'b1, 1'b0, 5'd3, 32'd0, 32'h0000_A5A5, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd4, 32'd0, 32'h0000_1111, 5'd3, 5'd4);
    #1;
    check("pre_rst_x3", bus.rs1_data_out, 32'h0000_A5A5);
    check("pre_rst_x4", bus.rs2_data_out, 32'h0000_1111);
    rst_n = 1'b0;
    #1;
    check("rst_x3", bus.rs1_data_out, 32'd0);
    check("rst_x4", bus.rs2_data_out, 32'd0);
    check("rst_count", bus.wb_count_out, 32'd0);
    check("rst_we", {31'd0, bus.wb_we_out}, 32'd0);
    check("rst_wb_data", bus.wb_data_out, 32'h0000_1111);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd4, 32'd0, 32'd0, 5'd3, 5'd4);
    #1;
    check("post_rst_x3", bus.rs1_data_out, 32'd0);
    check("post_rst_x4", bus.rs2_data_out, 32'd0);

    // Frozen pipeline re-commits the same value twice and counts both.
    drive(1'b1, 1'b1, 5'd31, 32'h0000_0077, 32'd0, 5'd31, 5'd30);
    repeat (2) next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd31, 5'd30);
    #1;
    check("freeze_count", bus.wb_count_out, 32'd2);
    check("freeze_x31", bus.rs1_data_out, 32'h0000_0077);
    check("freeze_x30", bus.rs2_data_out, 32'd0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural integer register file for the 5-stage RISC-V pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value (load data or ALU result), and commits it to x1..x31 on the clock edge. It also serves the two decode-stage read ports with same-cycle write-through bypass and keeps a count of committed register writes.

## Interface
- XLEN, 32: data width.
- NREGS, 32: architectural register count; x0 hardwired to zero.
- ADDR_W, 5: register index width, log2(NREGS).
- CNT_W, 32: write-commit counter width.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- mem_rd_data_in  in  XLEN  load data from MEM/WB.
- data_in  in  XLEN  ALU/address result from MEM/WB.
- mem_rd_addr_in  in  ADDR_W  destination register rd from MEM/WB.
- memToReg_in  in  1  1 = write load data, 0 = write ALU result.
- regWrite_in  in  1  write enable from MEM/WB; 0 = bubble.
- rs1_addr_in  in  ADDR_W  decode read port 1 index.
- rs2_addr_in  in  ADDR_W  decode read port 2 index.
- rs1_data_out  out  XLEN  read port 1 data, combinational.
- rs2_data_out  out  XLEN  read port 2 data, combinational.
- wb_data_out  out  XLEN  selected write-back value, combinational, for EX forwarding.
- wb_we_out  out  1  effective write enable: regWrite_in && mem_rd_addr_in != 0 && rst_n.
- wb_count_out  out  CNT_W  number of committed register writes.

## Operation
- wb_data_out = memToReg_in ? mem_rd_data_in : data_in. It is always driven, whatever the value of regWrite_in.
- Commit: on the rising clk edge with wb_we_out=1, regs[mem_rd_addr_in] <= wb_data_out.
- Writes to x0 are discarded. They do not count.
- Read port n:
  - index 0 returns 0.
  - If wb_we_out=1 and the index equals mem_rd_addr_in, the port returns wb_data_out (write-through bypass).
  - Otherwise the port returns regs[index].
- Both ports bypass independently. rs1 == rs2 == rd returns the bypass value on both ports.
- Counter: wb_count_out increments by 1 on each edge where wb_we_out=1. It wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset (rst_n low):
  - asynchronously clears regs[1..NREGS-1] and wb_count_out to 0.
  - forces wb_we_out to 0, so bypass is suppressed and all reads return 0.
  - wb_data_out stays the combinational mux output.
- Reset asserted mid-operation discards any write pending in that cycle.
- Deassertion is synchronised externally. The first commit is possible on the first rising edge with rst_n high.

## Timing
- Read latency 0: data is combinational from the address, the register array and the bypass.
- Write latency 1 edge: a value committed at edge N is visible from the array after edge N. During the cycle before edge N it is visible through the bypass.
- wb_count_out updates at the same edge as the commit.
- No handshake. One write per cycle. There are no stalls; the MEM/WB register holds its values when the pipeline freezes, so a frozen cycle with regWrite_in=1 re-commits the same value and counts again.
- Reset values: all outputs 0 except wb_data_out, which follows its inputs.

## Structure
- The shared package riscv_pkg holds:
  - XLEN, ADDR_W and NREGS constants.
  - the reg_idx_t typedef, width ADDR_W.
  - the X0 constant.
  - the WB_SEL_MEM/WB_SEL_ALU encoding of memToReg.
- One sub-module is natural: regfile_2r1w. It holds the array, the x0 rule, the asynchronous clear and the bypass compare.
- wb_regfile contains the write-back mux, the wb_we_out logic and the counter.

## Test plan
- Reset, then read all 32 indices on both ports -> every read 0; wb_count_out=0.
- regWrite=1, memToReg=0, rd=5, data_in=0x1234_5678; next cycle rs1=5 -> 0x1234_5678; count=1.
- In the same cycle: regWrite=1, memToReg=1, rd=7, mem_rd_data_in=0xDEAD_BEEF, rs1=rs2=7 -> both ports read 0xDEAD_BEEF before the edge.
- regWrite=1, rd=0, data_in=0xFFFF_FFFF -> rs1=0 reads 0, wb_we_out=0, count unchanged.
- Preload count to 0xFFFF_FFFF by forcing, then one commit -> count=0.
- Write x3=0xA5A5 and then assert rst_n low mid-cycle with regWrite=1, rd=4 -> x3 and x4 read 0 and count=0 immediately, with no clock edge.
